// File: rtl/sw_cmd_encoder.sv
// sw_cmd_encoder: debounces SW_SIZE switch inputs and turns every change of the
// debounced vector into a command word delivered over a valid/ready handshake.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   sw_raw     raw (asynchronous, bouncing) switch levels
//   sw_stable  debounced switch vector
//   cmd        command word (snapshot of sw_stable at a change event), 0 when idle
//   cmd_valid  cmd holds an unconsumed event
//   cmd_ready  consumer accepts cmd this cycle
//   overflow   sticky: an event was lost (cleared only by reset)
//
// Configuration macro: SW_CMD_FIFO_EN
//   defined   -> 4-entry event queue, a push to a full queue drops the new event
//   undefined -> single holding register, newest event overwrites an unconsumed one

module sw_cmd_encoder #(
  parameter int SW_SIZE         = 8,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_SIZE        = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SW_SIZE-1:0] sw_raw,
  output logic [SW_SIZE-1:0] sw_stable,
  output logic [SW_SIZE-1:0] cmd,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic               overflow
);

  typedef enum logic {ST_STABLE, ST_COUNTING} db_state_t;

  localparam logic [CNT_SIZE-1:0] CNT_LAST = CNT_SIZE'(DEBOUNCE_CYCLES - 1);

  logic [SW_SIZE-1:0]  sync1;
  logic [SW_SIZE-1:0]  sw_sync;
  db_state_t           state [SW_SIZE];
  logic [CNT_SIZE-1:0] cnt   [SW_SIZE];
  logic [SW_SIZE-1:0]  upd;
  logic                ev;
  logic                pop;

  // Two-flop synchronizer per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= '0;
      sw_sync <= '0;
    end else begin
      sync1   <= sw_raw;
      sw_sync <= sync1;
    end
  end

  // Bits whose debounce completes on this edge.
  always_comb begin
    upd = '0;
    for (int unsigned i = 0; i < SW_SIZE; i++) begin
      upd[i] = (state[i] == ST_COUNTING) && (sw_sync[i] != sw_stable[i]) &&
               (cnt[i] == CNT_LAST);
    end
  end

  // Per-bit debounce FSM. Entering COUNTING leaves the counter at 0, so the
  // stable value flips DEBOUNCE_CYCLES edges after the first mismatched sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_stable <= '0;
      ev        <= 1'b0;
      for (int unsigned i = 0; i < SW_SIZE; i++) begin
        state[i] <= ST_STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      ev <= |upd;
      for (int unsigned i = 0; i < SW_SIZE; i++) begin
        if (state[i] == ST_STABLE) begin
          if (sw_sync[i] != sw_stable[i]) state[i] <= ST_COUNTING;
        end else if (sw_sync[i] == sw_stable[i]) begin
          state[i] <= ST_STABLE;
          cnt[i]   <= '0;
        end else if (upd[i]) begin
          sw_stable[i] <= sw_sync[i];
          state[i]     <= ST_STABLE;
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // ev is registered, so the pushed vector is sw_stable as updated one edge earlier.
  assign pop = cmd_valid && cmd_ready;

`ifdef SW_CMD_FIFO_EN
  logic [SW_SIZE-1:0] mem [4];
  logic [1:0]         rd_ptr;
  logic [1:0]         wr_ptr;
  logic [2:0]         count;
  logic               push_ok;

  assign cmd_valid = (count != 3'd0);
  assign cmd       = cmd_valid ? mem[rd_ptr] : '0;
  assign push_ok   = ev && ((count != 3'd4) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (ev && !push_ok) overflow <= 1'b1;
      if (push_ok) begin
        mem[wr_ptr] <= sw_stable;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {2'b00, push_ok} - {2'b00, pop};
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (ev) begin
      cmd       <= sw_stable;
      cmd_valid <= 1'b1;
      if (cmd_valid && !cmd_ready) overflow <= 1'b1;
    end else if (pop) begin
      cmd       <= '0;
      cmd_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_sw_cmd_encoder.sv
// Self-checking bench for sw_cmd_encoder (DEBOUNCE_CYCLES=16). A behavioural
// model derives expected debounced values and the expected event queue; a
// negedge monitor compares the DUT against it every cycle. Directed sections
// check latencies, bounce rejection, multi-bit events, overflow and reset.

module tb_sw_cmd_encoder;
  localparam int SW = 8;
  localparam int D  = 16;
`ifdef SW_CMD_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] sw_raw;
  logic [SW-1:0] sw_stable;
  logic [SW-1:0] cmd;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          overflow;

  int checks   = 0;
  int failures = 0;

  sw_cmd_encoder #(.SW_SIZE(SW), .DEBOUNCE_CYCLES(D), .CNT_SIZE(5)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .sw_stable(sw_stable),
    .cmd(cmd), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a bit's debounced value follows the synchronized input once
  // it has disagreed for D+1 consecutive samples; each change is an event that
  // enters a queue of depth CAP one edge later.
  logic [SW-1:0] m_s1 = '0, m_s2 = '0, m_stab = '0;
  int            run [SW];
  bit            m_ev = 0, m_ovf = 0;
  logic [SW-1:0] mq [$];

  initial begin
    for (int i = 0; i < SW; i++) run[i] = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_s1 = '0; m_s2 = '0; m_stab = '0; m_ev = 0; m_ovf = 0;
        mq.delete();
        for (int i = 0; i < SW; i++) run[i] = 0;
      end else begin
        logic [SW-1:0] cur;
        if (mq.size() > 0 && cmd_ready) void'(mq.pop_front());
        if (m_ev) begin
          if (mq.size() < CAP) mq.push_back(m_stab);
          else begin
            m_ovf = 1;
            if (CAP == 1) mq[0] = m_stab;
          end
        end
        m_ev = 0;
        cur  = m_s2;
        m_s2 = m_s1;
        m_s1 = sw_raw;
        for (int i = 0; i < SW; i++) begin
          if (cur[i] != m_stab[i]) begin
            run[i]++;
            if (run[i] == D + 1) begin
              m_stab[i] = cur[i];
              run[i]    = 0;
              m_ev      = 1;
            end
          end else run[i] = 0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model away from the active edge.
  bit mon_en = 0;
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("mon_sw_stable", sw_stable, m_stab);
      chk("mon_cmd_valid", cmd_valid, mq.size() > 0);
      chk("mon_cmd", cmd, (mq.size() > 0) ? mq[0] : 8'h00);
      chk("mon_overflow", overflow, m_ovf);
    end
  end

  int            ev_cnt;
  logic [SW-1:0] last_cmd;

  // Advance n cycles, sampling just after each edge.
  task automatic cyc(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (cmd_valid) begin
        ev_cnt++;
        last_cmd = cmd;
      end
    end
  endtask

  // Count edges (first edge = 0) until sw_stable == v and until cmd_valid.
  task automatic latency(input logic [SW-1:0] v, output int t_st, output int t_v);
    t_st = -1; t_v = -1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (t_st < 0 && sw_stable == v) t_st = k;
      if (t_v < 0 && cmd_valid) t_v = k;
    end
  endtask

  initial begin
    int t_st, t_v, total;
    logic [SW-1:0] vals [5];
    vals[0] = 8'h01; vals[1] = 8'h03; vals[2] = 8'h07; vals[3] = 8'h0F; vals[4] = 8'h1F;
    rst_n = 1'b0; sw_raw = '0; cmd_ready = 1'b0;
    #23;
    chk("reset_sw_stable", sw_stable, 0);
    chk("reset_cmd", cmd, 0);
    chk("reset_cmd_valid", cmd_valid, 0);
    chk("reset_overflow", overflow, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1;

    // Clean 0x00 -> 0x01 with consumer ready.
    cmd_ready = 1'b1;
    sw_raw = 8'h01;
    latency(8'h01, t_st, t_v);
    chk("lat_sw_stable_edge", t_st, 18);
    chk("lat_cmd_valid_edge", t_v, 19);

    // Bounce on bit 0: 20 toggles every 5 cycles, then hold 1.
    sw_raw = 8'h00;
    cyc(40);
    ev_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      sw_raw[0] = ~sw_raw[0];
      cyc(5);
    end
    chk("bounce_no_event", ev_cnt, 0);
    sw_raw = 8'h01;
    cyc(40);
    chk("bounce_one_event", ev_cnt, 1);
    chk("bounce_cmd", last_cmd, 8'h01);

    // Two bits change together -> one event.
    sw_raw = 8'h00;
    cyc(40);
    ev_cnt = 0;
    sw_raw = 8'h06;
    cyc(40);
    chk("multi_one_event", ev_cnt, 1);
    chk("multi_cmd", last_cmd, 8'h06);

    // Events while the consumer stalls.
    sw_raw = 8'h00;
    cyc(40);
    cmd_ready = 1'b0;
`ifdef SW_CMD_FIFO_EN
    for (int e = 0; e < 5; e++) begin
      sw_raw = vals[e];
      cyc(25);
    end
    chk("fifo_overflow", overflow, 1);
    cmd_ready = 1'b1;
    for (int e = 0; e < 4; e++) begin
      chk("fifo_pop_valid", cmd_valid, 1);
      chk("fifo_pop_cmd", cmd, vals[e]);
      cyc(1);
    end
    chk("fifo_empty_valid", cmd_valid, 0);
`else
    for (int e = 0; e < 2; e++) begin
      sw_raw = vals[e];
      cyc(25);
    end
    chk("hold_cmd", cmd, 8'h03);
    chk("hold_cmd_valid", cmd_valid, 1);
    chk("hold_overflow", overflow, 1);
    cmd_ready = 1'b1;
    cyc(1);
    chk("hold_drained", cmd_valid, 0);
`endif

    // Randomized traffic against the model.
    total = 0;
    while (total < 2000) begin
      int hold;
      sw_raw = SW'($urandom);
      hold   = $urandom_range(1, 40);
      for (int k = 0; k < hold; k++) begin
        cmd_ready = ($urandom_range(0, 3) != 0);
        cyc(1);
      end
      total += hold;
    end

    // Reset in the middle of a debounce.
    cmd_ready = 1'b1;
    sw_raw = 8'h00;
    cyc(40);
    sw_raw = 8'h01;
    cyc(13);
    rst_n = 1'b0;
    #1;
    chk("midrst_sw_stable", sw_stable, 0);
    chk("midrst_cmd", cmd, 0);
    chk("midrst_cmd_valid", cmd_valid, 0);
    chk("midrst_overflow", overflow, 0);
    #2;
    rst_n = 1'b1;
    latency(8'h01, t_st, t_v);
    chk("midrst_sw_stable_edge", t_st, 18);
    chk("midrst_cmd_valid_edge", t_v, 19);
    cyc(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sw_cmd_encoder.md
SW_CMD_ENCODER -- requirements
Module: sw_cmd_encoder

Interface
REQ-001 SHALL have parameter SW_SIZE, default 8, number of switch inputs and command width.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, clk cycles a changed input must persist before acceptance (10 ms at 100 MHz); legal range 2 to 2^CNT_SIZE-1.
REQ-003 SHALL have parameter CNT_SIZE, default 20, debounce counter width.
REQ-004 SHALL have port clk, input, 1, system clock.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port sw_raw, input, SW_SIZE, asynchronous bouncing switch levels.
REQ-007 SHALL have port sw_stable, output, SW_SIZE, debounced switch vector.
REQ-008 SHALL have port cmd, output, SW_SIZE, command word (snapshot of sw_stable at a change event).
REQ-009 SHALL have port cmd_valid, output, 1, cmd holds an unconsumed event.
REQ-010 SHALL have port cmd_ready, input, 1, consumer accepts cmd this cycle.
REQ-011 SHALL have port overflow, output, 1, sticky flag: an event was lost.

Function
REQ-012 SHALL pass each sw_raw bit through a 2-flop synchronizer; synchronized value sw_sync lags sw_raw by 2 clk edges.
REQ-013 SHALL implement per bit a 2-state debounce FSM: STABLE (counter=0) and COUNTING.
REQ-014 STABLE -> COUNTING when sw_sync[i] != sw_stable[i]; counter increments by 1 each cycle in COUNTING.
REQ-015 COUNTING -> STABLE with counter cleared, sw_stable[i] unchanged, whenever sw_sync[i] == sw_stable[i] (bounce rejection).
REQ-016 COUNTING -> STABLE with sw_stable[i] <= sw_sync[i] on the edge where counter == DEBOUNCE_CYCLES-1 and mismatch persists; net: sw_stable changes DEBOUNCE_CYCLES edges after the first mismatched sw_sync sample.
REQ-017 SHALL generate one change event per cycle in which any sw_stable bit updates; multiple bits updating the same cycle produce one event carrying the full new vector.
REQ-018 SHALL enqueue the event vector; cmd_valid asserts the cycle after sw_stable updates when the queue was empty.
REQ-019 Handshake: transfer occurs on an edge with cmd_valid && cmd_ready; cmd and cmd_valid SHALL hold stable while cmd_valid && !cmd_ready.
REQ-020 cmd_ready while cmd_valid=0 SHALL have no effect.
REQ-021 Events are delivered in occurrence order; cmd SHALL be 0 whenever cmd_valid=0.
REQ-022 Simultaneous push and pop SHALL both take effect, including at full (no overflow in that case).
REQ-023 overflow SHALL set on a push to a full queue without simultaneous pop, and stay set until reset.

Reset
REQ-024 rst_n low SHALL asynchronously clear synchronizer flops, all counters (FSMs to STABLE), sw_stable, queue contents/pointers, cmd, cmd_valid, overflow to 0.
REQ-025 Reset mid-debounce SHALL discard the partial count; after release, a switch already high SHALL produce a full debounce then an event.

Configuration
REQ-026 Macro SW_CMD_FIFO_EN: defined -> 4-entry queue; push to full without pop drops the new event and sets overflow.
REQ-027 SW_CMD_FIFO_EN undefined -> single holding register; push while cmd_valid && !cmd_ready overwrites cmd with the newest vector and sets overflow; cmd_valid stays 1.

Verification (bench uses DEBOUNCE_CYCLES=16)
REQ-028 sw_raw 0x00->0x01 clean at edge N, cmd_ready=1 -> sw_stable=0x01 at N+18, cmd=0x01 cmd_valid=1 for one cycle at N+19.
REQ-029 sw_raw bit0 toggles every 5 cycles for 100 cycles then holds 1 -> no event during bounce; single event cmd=0x01 after 16 stable cycles.
REQ-030 sw_raw 0x00->0x06 same cycle -> exactly one event, cmd=0x06.
REQ-031 FIFO_EN, cmd_ready=0, five events 0x01,0x03,0x07,0x0F,0x1F -> overflow=1; raising cmd_ready pops 0x01,0x03,0x07,0x0F then cmd_valid=0.
REQ-032 FIFO_EN undefined, cmd_ready=0, events 0x01 then 0x03 -> cmd=0x03, cmd_valid=1, overflow=1.
REQ-033 rst_n pulsed low at count 10 of a debounce -> all outputs 0 immediately; after release, event fires 18 edges later, not earlier.
